pe_accum_adder_tree: RTL and testbench
======================================

// Module: pe_accum_adder_tree
// PURPOSE
//  Fully pipelined signed reduction tree with valid tracking and an optional
//  multi-beat accumulator, for PE dot-product columns. It sums NUM lanes per
//  beat and either emits each beat's sum or accumulates beats from
//  in_first..in_last into one saturating ACC_W result.
//  It streams with no backpressure and accepts one beat per cycle.
// PARAMETERS
//  SIZE   5   signed width of each din lane
//  NUM    40  lane count; NUM>=2, odd NUM allowed
//  ACC_W  32  accumulator/dout width; ACC_W < SIZE+$clog2(NUM) is an elaboration error
// PORTS
//  clk       in   1              single clock, all logic posedge
//  reset     in   1              synchronous, active-high
//  in_valid  in   1              beat present on din
//  in_first  in   1              first beat of accumulation group (qualified by in_valid)
//  in_last   in   1              last beat of accumulation group (qualified by in_valid)
//  acc_en    in   1              1=accumulate groups, 0=emit every beat's sum
//  din       in   SIZE x [0:NUM-1] signed lanes
//  out_valid out  1              dout/out_sat valid this cycle
//  dout      out  ACC_W          signed result
//  out_sat   out  1              result was clamped
// BEHAVIOUR
//  - Tree: L=$clog2(NUM) registered levels. Each level pairs neighbours and
//    grows width by 1 bit. An odd leftover is registered through
//    sign-extended. Tree sum width is TW=SIZE+L. No overflow is possible.
//  - in_valid, in_first, in_last and acc_en travel in a shift register that
//    stays aligned with the tree data. Only valid bits reset; data regs are
//    not reset.
//  - Output stage: 1 register after the tree. Latency is L+1 cycles from
//    din to out_valid (L=6 for NUM=40, so 7).
//  - acc_en=0 beat: dout = sign-extended tree sum, out_sat=0, and out_valid=1
//    at latency. Any open group is abandoned and produces no output.
//  - acc_en=1 beat:
//      * in_first=1, or no group open: acc = sum. The group is now open.
//      * Otherwise: acc = sat(acc + sum). The sticky sat flag ORs in the
//        clamp.
//      * in_last=1: out_valid=1, dout = new acc, out_sat = sticky|clamp.
//        The group closes and the sticky flag clears.
//      * in_first & in_last on the same beat gives a 1-beat group with
//        immediate output.
//      * in_first while a group is open: the old group is discarded without
//        output, and a new group starts.
//  - Saturation: clamp the signed result to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    The accumulator holds the clamped value.
//  - Non-valid cycles leave acc and group state unchanged. Gaps inside a
//    group are legal.
//  - Reset values: out_valid=0, out_sat=0, dout=0, acc=0, no group open, all
//    valid pipeline bits=0.
//  - Reset mid-operation: all in-flight beats and any open group are dropped.
//    out_valid is 0 from the cycle after reset is sampled until a new beat
//    is accepted after deassertion and reaches latency.
//  - FSM (2 states, output stage):
//      * IDLE -> OPEN on an acc_en=1 valid beat with in_last=0.
//      * OPEN -> IDLE on in_last, on an acc_en=0 beat, or on reset.
//      * OPEN -> OPEN on in_first, which restarts the group.
// TESTING
//  1 NUM=40,SIZE=5,acc_en=0; all din=15 one beat -> after 7 clk out_valid=1,dout=600,out_sat=0
//  2 NUM=5(odd),all din=-16 back-to-back 3 beats -> 3 consecutive out_valid, dout=-80 each
//  3 acc_en=1,NUM=4,din={1,2,3,4}; beats first,mid,gap,last -> single out_valid, dout=30
//  4 ACC_W=8,NUM=4,SIZE=5,din all 15, 4-beat group -> dout=127,out_sat=1; next 1-beat group din=1s -> dout=4,out_sat=0
//  5 open group 2 beats then in_first new group of 1 beat {1,1,1,1}+last -> only dout=4 emitted
//  6 reset asserted 2 cycles while 3 beats in flight -> no out_valid afterwards; next beat after release -> correct sum at latency

Source files
------------

// File: rtl/pe_accum_adder_tree.sv
// Pipelined signed adder tree over NUM lanes with optional saturating multi-beat accumulation.
// Latency $clog2(NUM)+1 cycles, one beat accepted per cycle, no backpressure.
module pe_accum_adder_tree #(
   parameter int SIZE  = 5,
   parameter int NUM   = 40,
   parameter int ACC_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic                    acc_en,
   input  logic signed [SIZE-1:0]  din [0:NUM-1],
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] dout,
   output logic                    out_sat
);
   localparam int L  = $clog2(NUM);
   localparam int TW = SIZE + L;

   if (NUM < 2) begin : g_chk_num
      $error("NUM must be at least 2");
   end
   if (ACC_W < TW) begin : g_chk_accw
      $error("ACC_W is narrower than the tree sum width");
   end

   // Each level pairs neighbours; an odd leftover is paired with zero, i.e. passed through sign-extended.
   for (genvar l = 1; l <= L; l++) begin : lvl_g
      localparam int PN = (NUM + (1 << (l - 1)) - 1) >> (l - 1);
      localparam int N  = (PN + 1) / 2;
      localparam int W  = SIZE + l;

      logic signed [W-2:0] src    [2*N];
      logic signed [W-1:0] node_d [N];
      logic signed [W-1:0] node_q [N];

      if (l == 1) begin : g_src
         always_comb begin
            for (int i = 0; i < 2*N; i++) src[i] = '0;
            for (int i = 0; i < PN; i++) src[i] = din[i];
         end
      end else begin : g_src
         always_comb begin
            for (int i = 0; i < 2*N; i++) src[i] = '0;
            for (int i = 0; i < PN; i++) src[i] = lvl_g[l-1].node_q[i];
         end
      end

      always_comb begin
         for (int i = 0; i < N; i++) begin
            node_d[i] = $signed({src[2*i][W-2], src[2*i]}) + $signed({src[2*i+1][W-2], src[2*i+1]});
         end
      end

      always_ff @(posedge clk) begin
         node_q <= node_d;
      end
   end

   logic [L-1:0] vld_d, vld_q, first_d, first_q, last_d, last_q, aen_d, aen_q;

   always_comb begin
      vld_d[0]   = in_valid;
      first_d[0] = in_first;
      last_d[0]  = in_last;
      aen_d[0]   = acc_en;
      for (int k = 1; k < L; k++) begin
         vld_d[k]   = vld_q[k-1];
         first_d[k] = first_q[k-1];
         last_d[k]  = last_q[k-1];
         aen_d[k]   = aen_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      aen_q   <= aen_d;
   end

   typedef enum logic {IDLE, OPEN} state_t;
   state_t state_d, state_q;

   logic signed [TW-1:0]    tree_sum;
   logic signed [ACC_W-1:0] sum_ext, acc_new, acc_d, acc_q, dout_d, dout_q;
   logic signed [ACC_W:0]   wide;
   logic t_vld, t_first, t_last, t_aen;
   logic restart, clamp, sticky_new, sticky_d, sticky_q;
   logic out_valid_d, out_valid_q, out_sat_d, out_sat_q;

   assign tree_sum = lvl_g[L].node_q[0];
   assign t_vld    = vld_q[L-1];
   assign t_first  = first_q[L-1];
   assign t_last   = last_q[L-1];
   assign t_aen    = aen_q[L-1];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      out_valid_d = 1'b0;
      dout_d      = dout_q;
      out_sat_d   = out_sat_q;

      sum_ext = ACC_W'(tree_sum);
      restart = t_first | (state_q == IDLE);
      wide    = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_ext);
      clamp   = 1'b0;
      acc_new = wide[ACC_W-1:0];
      if (restart) begin
         acc_new = sum_ext;
      end else if (wide[ACC_W] != wide[ACC_W-1]) begin
         clamp   = 1'b1;
         acc_new = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      sticky_new = (restart ? 1'b0 : sticky_q) | clamp;

      if (t_vld) begin
         if (!t_aen) begin
            out_valid_d = 1'b1;
            dout_d      = sum_ext;
            out_sat_d   = 1'b0;
            state_d     = IDLE;
            sticky_d    = 1'b0;
         end else begin
            acc_d = acc_new;
            if (t_last) begin
               out_valid_d = 1'b1;
               dout_d      = acc_new;
               out_sat_d   = sticky_new;
               state_d     = IDLE;
               sticky_d    = 1'b0;
            end else begin
               state_d  = OPEN;
               sticky_d = sticky_new;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_pe_accum_adder_tree.sv
// Bench for pe_accum_adder_tree: three parameterisations driven from one process,
// outputs checked against a per-instance queue of expected results and arrival cycles.
module tb_pe_accum_adder_tree;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic v40, f40, l40, a40, ov40, os40;
   logic signed [4:0]  din40 [0:39];
   logic signed [31:0] do40;
   logic v5, f5, l5, a5, ov5, os5;
   logic signed [4:0]  din5 [0:4];
   logic signed [31:0] do5;
   logic v4, f4, l4, a4, ov4, os4;
   logic signed [4:0]  din4 [0:3];
   logic signed [7:0]  do4;

   pe_accum_adder_tree #(.SIZE(5), .NUM(40), .ACC_W(32)) u40 (
      .clk(clk), .reset(reset), .in_valid(v40), .in_first(f40), .in_last(l40), .acc_en(a40),
      .din(din40), .out_valid(ov40), .dout(do40), .out_sat(os40));
   pe_accum_adder_tree #(.SIZE(5), .NUM(5), .ACC_W(32)) u5 (
      .clk(clk), .reset(reset), .in_valid(v5), .in_first(f5), .in_last(l5), .acc_en(a5),
      .din(din5), .out_valid(ov5), .dout(do5), .out_sat(os5));
   pe_accum_adder_tree #(.SIZE(5), .NUM(4), .ACC_W(8)) u4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_first(f4), .in_last(l4), .acc_en(a4),
      .din(din4), .out_valid(ov4), .dout(do4), .out_sat(os4));

   typedef struct {
      logic signed [31:0] dout;
      logic               sat;
      int                 cyc;
      string              name;
   } exp_t;

   typedef struct {
      logic  vld, acc, first, last;
      int    lane [4];
      logic  emit;
      int    exp_dout;
      logic  exp_sat;
      string name;
   } vec_t;

   exp_t sbq [3][$];
   vec_t tbl [$];
   int n_chk = 0;
   int n_pass = 0;
   int cnt = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic mon_one(input int d, input logic ov, input logic signed [31:0] dv, input logic sv);
      exp_t e;
      if (ov === 1'b1) begin
         if (sbq[d].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out_dut%0d: got out_valid=1 dout=%0d at cycle %0d, expected no output", d, dv, cnt);
         end else begin
            e = sbq[d].pop_front();
            chk({e.name, "_dout"}, dv, e.dout);
            chk({e.name, "_sat"}, sv, e.sat);
            chk({e.name, "_cycle"}, cnt, e.cyc);
         end
      end
      while (sbq[d].size() > 0 && sbq[d][0].cyc < cnt) begin
         e = sbq[d].pop_front();
         n_chk++;
         $display("FAIL %s_missing: got no out_valid by cycle %0d, expected at cycle %0d", e.name, cnt, e.cyc);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      cnt++;
      mon_one(0, ov40, do40, os40);
      mon_one(1, ov5, do5, os5);
      mon_one(2, ov4, do4, os4);
   endtask

   task automatic push(input int d, input int dv, input logic sv, input string nm, input int lat);
      exp_t e;
      e.dout = dv;
      e.sat  = sv;
      e.cyc  = cnt + lat;
      e.name = nm;
      sbq[d].push_back(e);
   endtask

   task automatic idle(input int n);
      v40 = 1'b0; v5 = 1'b0; v4 = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic row(input logic vld, input logic acc, input logic first, input logic last,
                      input int a, input int b, input int c, input int d,
                      input logic emit, input int ed, input logic es, input string nm);
      vec_t r;
      r.vld = vld; r.acc = acc; r.first = first; r.last = last;
      r.lane[0] = a; r.lane[1] = b; r.lane[2] = c; r.lane[3] = d;
      r.emit = emit; r.exp_dout = ed; r.exp_sat = es; r.name = nm;
      tbl.push_back(r);
   endtask

   initial begin
      int s;
      reset = 1'b1;
      v40 = 0; f40 = 0; l40 = 0; a40 = 0;
      v5 = 0; f5 = 0; l5 = 0; a5 = 0;
      v4 = 0; f4 = 0; l4 = 0; a4 = 0;
      for (int i = 0; i < 40; i++) din40[i] = '0;
      for (int i = 0; i < 5; i++) din5[i] = '0;
      for (int i = 0; i < 4; i++) din4[i] = '0;
      repeat (3) cyc();
      chk("rst_ov40", ov40, 0); chk("rst_do40", do40, 0); chk("rst_os40", os40, 0);
      chk("rst_ov5", ov5, 0);   chk("rst_do5", do5, 0);   chk("rst_os5", os5, 0);
      chk("rst_ov4", ov4, 0);   chk("rst_do4", do4, 0);   chk("rst_os4", os4, 0);
      reset = 1'b0;
      cyc();

      // NUM=40: uniform max lanes, uniform min lanes, then a distinct per-lane pattern.
      v40 = 1; a40 = 0; f40 = 0; l40 = 0;
      for (int i = 0; i < 40; i++) din40[i] = 5'sd15;
      push(0, 600, 0, "t1_all15", 7);
      cyc();
      for (int i = 0; i < 40; i++) din40[i] = -5'sd16;
      push(0, -640, 0, "t1_allm16", 7);
      cyc();
      s = 0;
      for (int i = 0; i < 40; i++) begin
         din40[i] = 5'((i * 7) % 32 - 16);
         s += (i * 7) % 32 - 16;
      end
      push(0, s, 0, "t1_pattern", 7);
      cyc();
      v40 = 0;

      // NUM=5 (odd): three back-to-back beats, then a pattern exercising the leftover lane.
      v5 = 1; a5 = 0; f5 = 0; l5 = 0;
      for (int i = 0; i < 5; i++) din5[i] = -5'sd16;
      for (int k = 0; k < 3; k++) begin
         push(1, -80, 0, "t2_b2b", 4);
         cyc();
      end
      din5[0] = -5'sd16; din5[1] = 5'sd15; din5[2] = 5'sd3; din5[3] = -5'sd7; din5[4] = 5'sd2;
      push(1, -3, 0, "t2_odd_pattern", 4);
      cyc();
      idle(10);

      // NUM=4, ACC_W=8 group/saturation vectors, applied back to back.
      row(1,1,1,0,   1,  2,  3,  4, 0,    0, 0, "t3_gap");
      row(1,1,0,0,   1,  2,  3,  4, 0,    0, 0, "t3_gap");
      row(0,1,0,1,   9,  9,  9,  9, 0,    0, 0, "t3_gap");
      row(1,1,0,1,   1,  2,  3,  4, 1,   30, 0, "t3_gap");
      row(1,1,1,0,  15, 15, 15, 15, 0,    0, 0, "t4_sat_pos");
      row(1,1,0,0,  15, 15, 15, 15, 0,    0, 0, "t4_sat_pos");
      row(1,1,0,0,  15, 15, 15, 15, 0,    0, 0, "t4_sat_pos");
      row(1,1,0,1,  15, 15, 15, 15, 1,  127, 1, "t4_sat_pos");
      row(1,1,1,1,   1,  1,  1,  1, 1,    4, 0, "t4_one_beat");
      row(1,1,1,0,  15, 15, 15, 15, 0,    0, 0, "t5_restart");
      row(1,1,0,0,  15, 15, 15, 15, 0,    0, 0, "t5_restart");
      row(1,1,0,0,  15, 15, 15, 15, 0,    0, 0, "t5_restart");
      row(1,1,1,1,   1,  1,  1,  1, 1,    4, 0, "t5_restart");
      row(1,1,1,0,  15, 15, 15, 15, 0,    0, 0, "abandon");
      row(1,0,0,0, -16,-16,-16,-16, 1,  -64, 0, "abandon_emit");
      row(1,1,0,1,   1,  1,  1,  1, 1,    4, 0, "abandon_nogrp");
      row(1,1,1,0,  15, 15, 15, 15, 0,    0, 0, "edge_pos");
      row(1,1,0,0,  15, 15, 15, 15, 0,    0, 0, "edge_pos");
      row(1,1,0,1,   7,  0,  0,  0, 1,  127, 0, "edge_pos");
      row(1,1,1,0, -16,-16,-16,-16, 0,    0, 0, "edge_neg");
      row(1,1,0,1, -16,-16,-16,-16, 1, -128, 0, "edge_neg");
      row(1,1,1,0, -16,-16,-16,-16, 0,    0, 0, "sat_neg");
      row(1,1,0,0, -16,-16,-16,-16, 0,    0, 0, "sat_neg");
      row(1,1,0,1, -16,-16,-16,-16, 1, -128, 1, "sat_neg");
      row(1,0,0,0,  -5,  3, 15,-16, 1,   -3, 0, "emit_mixed");
      row(1,0,1,1,   7, -8,  2,  1, 1,    2, 0, "emit_flags");
      foreach (tbl[r]) begin
         v4 = tbl[r].vld; a4 = tbl[r].acc; f4 = tbl[r].first; l4 = tbl[r].last;
         for (int i = 0; i < 4; i++) din4[i] = 5'(tbl[r].lane[i]);
         if (tbl[r].emit) push(2, tbl[r].exp_dout, tbl[r].exp_sat, tbl[r].name, 3);
         cyc();
      end
      idle(6);

      // Reset while beats are in flight and a group is open: everything is dropped.
      v4 = 1; a4 = 1; f4 = 1; l4 = 0;
      for (int i = 0; i < 4; i++) din4[i] = 5'sd15;
      cyc();
      v4 = 0;
      v40 = 1; a40 = 0;
      for (int i = 0; i < 40; i++) din40[i] = 5'sd15;
      repeat (3) cyc();
      v40 = 0;
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("t6_quiet40", ov40, 0);
         chk("t6_quiet4", ov4, 0);
      end
      v4 = 1; a4 = 1; f4 = 0; l4 = 1;
      for (int i = 0; i < 4; i++) din4[i] = 5'sd1;
      push(2, 4, 0, "t6_grp_dropped", 3);
      v40 = 1; a40 = 0;
      for (int i = 0; i < 40; i++) din40[i] = (i % 2 == 1) ? -5'sd3 : 5'sd7;
      push(0, 80, 0, "t6_after_rst", 7);
      cyc();
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
